capture_sdram_writer: RTL and testbench

Capture-side DMA engine that drains the 256-bit sample stream from the capture datapath into HPS SDRAM through the FPGA-to-SDRAM Avalon-MM port (27-bit word address, 256-bit data, 8-bit burstcount). It buffers samples in an internal FIFO and issues fixed-size write bursts once enough data is queued. It reports progress and sample loss to the lightweight-bridge register block. It runs in the SDRAM-port clock domain; the capture stream is already synchronised into this domain upstream.

---
 rtl/la_dma_pkg.sv | 25 ++
 rtl/capture_sdram_writer_if.sv | 33 +++
 rtl/sdram_wr_fifo.sv | 61 ++++++
 rtl/capture_sdram_writer.sv | 186 ++++++++++++++++++
 tb/tb_capture_sdram_writer.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/la_dma_pkg.sv
// Shared types and constants for the capture-side SDRAM DMA writer.
// Holds the Avalon port geometry, the writer state enum and the burst sizing helper.
package la_dma_pkg;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 256;
  localparam int BCNT_W = 8;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [BE_W-1:0] BYTEENABLE_ALL = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    BURST = 2'd2,
    DONE  = 2'd3
  } dma_state_e;

  // Burst length for the next burst: a full burst, or whatever is left of the run.
  function automatic logic [BCNT_W-1:0] burst_len_for(input logic [31:0] remaining,
                                                      input logic [31:0] max_len);
    return BCNT_W'((remaining >= max_len) ? max_len : remaining);
  endfunction

endpackage

// File: rtl/capture_sdram_writer_if.sv
// Avalon-MM write master bundle between the capture writer and the FPGA-to-SDRAM port.
interface capture_sdram_writer_if;
  import la_dma_pkg::*;

  logic [ADDR_W-1:0] avm_address;
  logic [BCNT_W-1:0] avm_burstcount;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_read;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_burstcount,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    output avm_read,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_burstcount,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    input  avm_read,
    output avm_waitrequest
  );

endinterface

// File: rtl/sdram_wr_fifo.sv
// Show-ahead sample FIFO with occupancy count and synchronous flush.
// A push on a full FIFO is taken when a pop happens in the same cycle.
module sdram_wr_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_q];
  assign count   = count_q;

  // Sample storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/capture_sdram_writer.sv
// Capture stream to SDRAM DMA: queues samples in a FIFO and drains them as
// fixed-size Avalon-MM write bursts, reporting progress and sample loss.
module capture_sdram_writer
  import la_dma_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [31:0]            length,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [31:0]            words_written,
  capture_sdram_writer_if.master avm
);

  localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_e          state_q;
  dma_state_e          state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         remaining_q;
  logic [31:0]         length_q;
  logic [31:0]         pushed_q;
  logic [31:0]         words_q;
  logic [BCNT_W-1:0]   blen_q;
  logic [BCNT_W-1:0]   beat_cnt_q;
  logic [BCNT_W-1:0]   blen_fill;
  logic                overflow_q;
  logic                abort_pend_q;
  logic                wr_active;
  logic                accept;
  logic                last_beat;
  logic                burst_ready;
  logic                start_run;
  logic                intake;
  logic                push_ok;
  logic                fifo_flush;
  logic                fifo_full;
  logic [FIFO_CW-1:0]  fifo_count;
  logic [DATA_W-1:0]   fifo_head;

  assign start_run   = (state_q == IDLE) && start;
  assign blen_fill   = burst_len_for(remaining_q, 32'(BURST_LEN));
  assign burst_ready = 32'(fifo_count) >= 32'(blen_fill);
  assign accept      = wr_active && !avm.avm_waitrequest;
  assign last_beat   = accept && (beat_cnt_q == blen_q - 1'b1);

  // Intake is gated by the pushed total, so dropped samples do not shorten the run.
  assign intake     = busy && in_valid && (pushed_q < length_q);
  assign push_ok    = intake && (!fifo_full || accept);
  assign fifo_flush = (state_q == DONE) || start_run;

  sdram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (fifo_flush),
    .push      (push_ok),
    .push_data (in_data),
    .pop       (accept),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort in FILL ends the run at once; in BURST it waits for the burst to finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (length == 32'd0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (abort) begin
          state_d = DONE;
        end else if (burst_ready) begin
          state_d = BURST;
        end
      end
      BURST: begin
        if (last_beat) begin
          if ((remaining_q == 32'(blen_q)) || abort || abort_pend_q) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    wr_active = 1'b0;
    case (state_q)
      FILL:  busy = 1'b1;
      BURST: begin
        busy      = 1'b1;
        wr_active = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q       <= '0;
      remaining_q  <= '0;
      length_q     <= '0;
      pushed_q     <= '0;
      words_q      <= '0;
      blen_q       <= '0;
      beat_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (start_run) begin
        addr_q       <= base_addr;
        remaining_q  <= length;
        length_q     <= length;
        pushed_q     <= '0;
        words_q      <= '0;
        overflow_q   <= 1'b0;
        abort_pend_q <= 1'b0;
      end
      if (intake) begin
        if (push_ok) begin
          pushed_q <= pushed_q + 32'd1;
        end else begin
          overflow_q <= 1'b1;
        end
      end
      if ((state_q == FILL) && (state_d == BURST)) begin
        blen_q     <= blen_fill;
        beat_cnt_q <= '0;
      end
      if (accept) begin
        words_q    <= words_q + 32'd1;
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (last_beat) begin
        addr_q      <= addr_q + ADDR_W'(blen_q);
        remaining_q <= remaining_q - 32'(blen_q);
      end
      if ((state_q == BURST) && abort) begin
        abort_pend_q <= 1'b1;
      end else if (state_q == DONE) begin
        abort_pend_q <= 1'b0;
      end
    end
  end

  assign overflow           = overflow_q;
  assign words_written      = words_q;
  assign avm.avm_address    = addr_q;
  assign avm.avm_burstcount = blen_q;
  assign avm.avm_write      = wr_active;
  assign avm.avm_writedata  = fifo_head;
  assign avm.avm_byteenable = BYTEENABLE_ALL;
  assign avm.avm_read       = 1'b0;

endmodule

// File: tb/tb_capture_sdram_writer.sv
// Bench for capture_sdram_writer: random stimulus against a run-level reference
// model (sample queue, burst plan derived from length/base), checked every cycle.
module tb_capture_sdram_writer;
  import la_dma_pkg::*;

  localparam int BL    = 16;
  localparam int DEPTH = 64;
  localparam int P_IDLE = 0, P_FILL = 1, P_BURST = 2, P_DONE = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [31:0]       length = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              busy, done, overflow;
  logic [31:0]       words_written;

  capture_sdram_writer_if avm();

  capture_sdram_writer #(.BURST_LEN(BL), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .length        (length),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .words_written (words_written),
    .avm           (avm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Stimulus knobs and random per-cycle drive of stream and waitrequest.
  int valid_pct = 0;
  int wait_pct  = 0;

  initial begin
    avm.avm_waitrequest = 1'b0;
    forever begin
      logic [DATA_W-1:0] d;
      @(posedge clk);
      #1;
      for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
      in_data  = d;
      in_valid = (int'($urandom_range(99)) < valid_pct);
      avm.avm_waitrequest = (int'($urandom_range(99)) < wait_pct);
    end
  end

  // Reference model state, described at run/transaction level.
  bit                mon_en = 0;
  int                cyc = 0;
  int                phase = P_IDLE;
  logic [DATA_W-1:0] q[$];
  int                m_len = 0, m_pushed = 0, m_words = 0, m_beats = 0, m_blen = 0;
  bit                m_ovf = 0, m_pend = 0, m_rec = 0;
  logic [ADDR_W-1:0] m_base = '0, m_baddr = '0;
  int                start_cyc = 0, done_cyc = 0, done_cnt = 0;
  bit                busy_seen = 0;
  logic [ADDR_W-1:0] rec_addr[$];
  int                rec_bcnt[$];
  int                rec_cyc[$];

  always @(negedge clk) begin
    if (mon_en) begin
      int qsz;
      bit acc, pushq;
      logic [DATA_W-1:0] sample;
      cyc++;
      chk("busy", 256'(busy), 256'(phase == P_FILL || phase == P_BURST));
      chk("done", 256'(done), 256'(phase == P_DONE));
      chk("avm_write", 256'(avm.avm_write), 256'(phase == P_BURST));
      chk("overflow", 256'(overflow), 256'(m_ovf));
      chk("words_written", 256'(words_written), 256'(m_words));
      chk("avm_read", 256'(avm.avm_read), 256'(0));
      chk("byteenable", 256'(avm.avm_byteenable), {224'd0, 32'hFFFF_FFFF});
      if (busy === 1'b1) busy_seen = 1;
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (phase == P_BURST) begin
        if (!m_rec) begin
          rec_addr.push_back(avm.avm_address);
          rec_bcnt.push_back(int'(avm.avm_burstcount));
          rec_cyc.push_back(cyc);
          m_rec = 1;
        end
        chk("avm_address", 256'(avm.avm_address), 256'(m_baddr));
        chk("avm_burstcount", 256'(avm.avm_burstcount), 256'(m_blen));
        if (q.size() == 0) fail_now("writedata_model_empty");
        else chk("avm_writedata", avm.avm_writedata, q[0]);
      end

      qsz    = q.size();
      acc    = (phase == P_BURST) && (avm.avm_waitrequest == 1'b0);
      pushq  = 0;
      sample = in_data;
      if (!reset_n) begin
        phase = P_IDLE;
        q.delete();
        m_ovf = 0; m_words = 0; m_pend = 0; m_pushed = 0; m_len = 0;
      end else begin
        if ((phase == P_FILL || phase == P_BURST) && in_valid && m_pushed < m_len) begin
          if (qsz < DEPTH || acc) begin
            pushq = 1;
            m_pushed++;
          end else begin
            m_ovf = 1;
          end
        end
        case (phase)
          P_IDLE: if (start) begin
            m_base = base_addr; m_len = int'(length);
            m_words = 0; m_ovf = 0; m_pushed = 0; m_pend = 0;
            q.delete();
            start_cyc = cyc;
            phase = (length == 0) ? P_DONE : P_FILL;
          end
          P_FILL: begin
            if (abort) phase = P_DONE;
            else begin
              m_blen = (m_len - m_words >= BL) ? BL : m_len - m_words;
              if (qsz >= m_blen) begin
                phase = P_BURST;
                m_beats = 0;
                m_rec = 0;
                m_baddr = m_base + ADDR_W'(m_words);
              end
            end
          end
          P_BURST: begin
            if (abort) m_pend = 1;
            if (acc) begin
              void'(q.pop_front());
              m_words++;
              m_beats++;
              if (m_beats == m_blen) phase = (m_words == m_len || m_pend) ? P_DONE : P_FILL;
            end
          end
          default: begin
            q.delete();
            phase = P_IDLE;
          end
        endcase
        if (pushq) q.push_back(sample);
      end
    end
  end

  task automatic pulse_start(input logic [ADDR_W-1:0] b, input int len, input bit with_abort);
    rec_addr.delete(); rec_bcnt.delete(); rec_cyc.delete();
    busy_seen = 0;
    @(posedge clk); #1;
    base_addr = b; length = len; start = 1'b1; abort = with_abort;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) fail_now(name);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_write(input string name, input int budget);
    for (int i = 0; i < budget && avm.avm_write !== 1'b1; i++) @(negedge clk);
    if (avm.avm_write !== 1'b1) fail_now(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_done"}, 256'(done), 256'(0));
    chk({tag, "_overflow"}, 256'(overflow), 256'(0));
    chk({tag, "_words"}, 256'(words_written), 256'(0));
    chk({tag, "_write"}, 256'(avm.avm_write), 256'(0));
    chk({tag, "_address"}, 256'(avm.avm_address), 256'(0));
    chk({tag, "_burstcount"}, 256'(avm.avm_burstcount), 256'(0));
  endtask

  initial begin
    int len;
    int d0;
    @(posedge clk); #1;
    mon_en = 1;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Two full bursts, continuous input, no stalls; timing pinned by hand.
    valid_pct = 100; wait_pct = 0;
    d0 = done_cnt;
    pulse_start(27'h100, 32, 0);
    wait_done("done_len32", 200);
    chk("len32_bursts", 256'(rec_addr.size()), 256'(2));
    if (rec_addr.size() >= 2) begin
      chk("len32_addr0", 256'(rec_addr[0]), 256'(27'h100));
      chk("len32_bcnt0", 256'(rec_bcnt[0]), 256'(16));
      chk("len32_addr1", 256'(rec_addr[1]), 256'(27'h110));
      chk("len32_bcnt1", 256'(rec_bcnt[1]), 256'(16));
      chk("len32_first_write_lat", 256'(rec_cyc[0] - start_cyc), 256'(18));
    end
    chk("len32_done_lat", 256'(done_cyc - start_cyc), 256'(51));
    chk("len32_done_once", 256'(done_cnt - d0), 256'(1));
    chk("len32_words", 256'(words_written), 256'(32));
    chk("len32_overflow", 256'(overflow), 256'(0));

    // Short tail burst, with the address wrapping past 2^27.
    pulse_start(27'h7FF_FFF8, 20, 0);
    wait_done("done_len20", 200);
    chk("len20_bursts", 256'(rec_addr.size()), 256'(2));
    if (rec_addr.size() >= 2) begin
      chk("len20_bcnt0", 256'(rec_bcnt[0]), 256'(16));
      chk("len20_addr1", 256'(rec_addr[1]), 256'(27'h000_0008));
      chk("len20_bcnt1", 256'(rec_bcnt[1]), 256'(4));
    end
    chk("len20_words", 256'(words_written), 256'(20));

    // Random stalls and gappy input.
    for (int r = 0; r < 3; r++) begin
      len = int'($urandom_range(30, 120));
      valid_pct = int'($urandom_range(40, 100));
      wait_pct = 50;
      pulse_start(ADDR_W'($urandom), len, 0);
      wait_done("done_random", 4000);
      chk("random_words", 256'(words_written), 256'(len));
    end

    // Long stall forces sample loss; the run still completes.
    valid_pct = 100; wait_pct = 100;
    pulse_start(27'h2000, 200, 0);
    repeat (200) @(posedge clk);
    #1;
    wait_pct = 0;
    wait_done("done_overflow", 2000);
    chk("ovf_flag", 256'(overflow), 256'(1));
    chk("ovf_words", 256'(words_written), 256'(200));

    // Abort mid-burst: burst finishes, run ends; new start clears the sticky flag.
    valid_pct = 100; wait_pct = 30;
    pulse_start(27'h3000, 64, 0);
    @(negedge clk);
    chk("restart_overflow_cleared", 256'(overflow), 256'(0));
    chk("restart_words_cleared", 256'(words_written), 256'(0));
    chk("restart_busy", 256'(busy), 256'(1));
    wait_write("abort_wait_write", 200);
    repeat (3) @(posedge clk);
    pulse_abort();
    wait_done("done_abort_burst", 500);
    chk("abort_words", 256'(words_written), 256'(16));
    chk("abort_bursts", 256'(rec_addr.size()), 256'(1));
    chk("abort_busy", 256'(busy), 256'(0));

    // Start and abort together: start wins; a later abort in FILL ends with no writes.
    valid_pct = 50; wait_pct = 0;
    pulse_start(27'h4000, 40, 1);
    @(negedge clk);
    chk("start_wins_busy", 256'(busy), 256'(1));
    repeat (3) @(posedge clk);
    pulse_abort();
    wait_done("done_abort_fill", 100);
    chk("fill_abort_words", 256'(words_written), 256'(0));
    chk("fill_abort_bursts", 256'(rec_addr.size()), 256'(0));

    // Reset in the middle of a burst, then a zero-length run.
    valid_pct = 100; wait_pct = 0;
    pulse_start(27'h5000, 64, 0);
    wait_write("reset_wait_write", 200);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("midburst_reset");
    d0 = done_cnt;
    pulse_start(27'h6000, 0, 0);
    @(negedge clk);
    chk("len0_done", 256'(done), 256'(1));
    chk("len0_busy", 256'(busy), 256'(0));
    repeat (4) @(negedge clk);
    chk("len0_done_once", 256'(done_cnt - d0), 256'(1));
    chk("len0_no_write", 256'(rec_addr.size()), 256'(0));
    chk("len0_never_busy", 256'(busy_seen), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "global timeout");
  end

endmodule
